// File: rtl/bus_cycle_controller.sv
// bus_cycle_controller: 68000 bus-cycle controller. Decodes each CPU cycle
// into a chip select, counts per-region wait states, and answers with DTACK,
// or with DTERROR on a decode miss or a ready timeout. It can optionally hold
// each cycle until a single-step pulse arrives.
module bus_cycle_controller #(
   parameter int                              NUM_REGIONS  = 4,
   parameter int                              ADDR_WIDTH   = 24,
   parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE =
      {24'hC00000, 24'h100000, 24'h080000, 24'h000000},
   parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = {4{24'hF80000}},
   parameter logic [NUM_REGIONS*4-1:0]        REGION_WAIT  = {4'd1, 4'd0, 4'd0, 4'd2},
   parameter logic [NUM_REGIONS-1:0]          REGION_EXT   = 4'b1000,
   parameter int                              BERR_TIMEOUT = 64
) (
   input  logic                   MCLK_IN,
   input  logic                   RESET_IN,
   input  logic                   AS_IN,
   input  logic                   WR_IN,
   input  logic                   UDS_IN,
   input  logic                   LDS_IN,
   input  logic [ADDR_WIDTH-1:0]  ADDR_IN,
   input  logic                   STEPEN_IN,
   input  logic                   STEP_IN,
   input  logic [NUM_REGIONS-1:0] EXT_READY_IN,
   output logic [NUM_REGIONS-1:0] CS,
   output logic                   OE,
   output logic                   WE_U,
   output logic                   WE_L,
   output logic                   DTACK,
   output logic                   DTERROR,
   output logic                   BUSY,
   output logic [2:0]             HIT_INDEX
);

   localparam int TW = $clog2(BERR_TIMEOUT);
   localparam logic [TW-1:0] T_LIMIT = TW'(BERR_TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_STEPHOLD, S_ACK, S_ERROR} state_t;

   state_t                 r_state;
   logic                   r_as_s1, r_as_s;
   logic                   r_step_s1, r_step_s, r_step_d;
   logic [NUM_REGIONS-1:0] r_cs;
   logic                   r_oe, r_we_u, r_we_l, r_dtack, r_dterror;
   logic [2:0]             r_hit_index;
   logic [3:0]             r_wcnt;
   logic [TW-1:0]          r_tcnt;
   logic                   r_need_ext;

   logic                   w_hit;
   logic [2:0]             w_hit_idx;
   logic [NUM_REGIONS-1:0] w_hit_cs;
   logic [3:0]             w_hit_wait;
   logic                   w_hit_ext;
   logic                   w_ready;
   logic                   w_step_rise;

   // Address decode; scanning downward lets the lowest hitting region win.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_idx  = 3'd0;
      w_hit_cs   = '0;
      w_hit_wait = 4'd0;
      w_hit_ext  = 1'b0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if ((ADDR_IN & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
             REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
            w_hit       = 1'b1;
            w_hit_idx   = 3'(i);
            w_hit_cs    = '0;
            w_hit_cs[i] = 1'b1;
            w_hit_wait  = REGION_WAIT[i*4 +: 4];
            w_hit_ext   = REGION_EXT[i];
         end
      end
   end

   // The registered one-hot CS selects the matching external ready line.
   assign w_ready     = ~r_need_ext | (|(EXT_READY_IN & r_cs));
   assign w_step_rise = r_step_s & ~r_step_d;

   // Synchronizers, bus-cycle FSM and registered strobes.
   always_ff @(posedge MCLK_IN) begin
      if (RESET_IN) begin
         r_state     <= S_IDLE;
         r_as_s1     <= 1'b0;
         r_as_s      <= 1'b0;
         r_step_s1   <= 1'b0;
         r_step_s    <= 1'b0;
         r_step_d    <= 1'b0;
         r_cs        <= '0;
         r_oe        <= 1'b0;
         r_we_u      <= 1'b0;
         r_we_l      <= 1'b0;
         r_dtack     <= 1'b0;
         r_dterror   <= 1'b0;
         r_hit_index <= 3'd0;
         r_wcnt      <= 4'd0;
         r_tcnt      <= '0;
         r_need_ext  <= 1'b0;
      end else begin
         r_as_s1   <= AS_IN;
         r_as_s    <= r_as_s1;
         r_step_s1 <= STEP_IN;
         r_step_s  <= r_step_s1;
         r_step_d  <= r_step_s;
         case (r_state)
            S_IDLE: begin
               if (r_as_s) r_state <= S_DECODE;
            end
            S_DECODE: begin
               if (!r_as_s) begin
                  r_cs <= '0; r_oe <= 1'b0; r_we_u <= 1'b0; r_we_l <= 1'b0;
                  r_state <= S_IDLE;
               end else if (w_hit) begin
                  r_cs        <= w_hit_cs;
                  r_oe        <= ~WR_IN;
                  r_we_u      <= WR_IN & UDS_IN;
                  r_we_l      <= WR_IN & LDS_IN;
                  r_wcnt      <= w_hit_wait;
                  r_tcnt      <= '0;
                  r_hit_index <= w_hit_idx;
                  r_need_ext  <= w_hit_ext;
                  r_state     <= S_WAIT;
               end else begin
                  r_cs        <= '0;
                  r_hit_index <= 3'd7;
                  r_dterror   <= 1'b1;
                  r_state     <= S_ERROR;
               end
            end
            S_WAIT: begin
               if (!r_as_s) begin
                  r_cs <= '0; r_oe <= 1'b0; r_we_u <= 1'b0; r_we_l <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  if (r_tcnt != '1)    r_tcnt <= r_tcnt + TW'(1);
                  if (r_wcnt != 4'd0)  r_wcnt <= r_wcnt - 4'd1;
                  // Timeout wins over a ready arriving in the same cycle.
                  if (r_tcnt == T_LIMIT) begin
                     r_cs <= '0; r_oe <= 1'b0; r_we_u <= 1'b0; r_we_l <= 1'b0;
                     r_dterror <= 1'b1;
                     r_state   <= S_ERROR;
                  end else if (r_wcnt == 4'd0 && w_ready) begin
                     if (STEPEN_IN) begin
                        r_state <= S_STEPHOLD;
                     end else begin
                        r_dtack <= 1'b1;
                        r_state <= S_ACK;
                     end
                  end
               end
            end
            S_STEPHOLD: begin
               // tcnt is not touched here, so a held cycle never times out.
               if (!r_as_s) begin
                  r_cs <= '0; r_oe <= 1'b0; r_we_u <= 1'b0; r_we_l <= 1'b0;
                  r_state <= S_IDLE;
               end else if (w_step_rise || !STEPEN_IN) begin
                  r_dtack <= 1'b1;
                  r_state <= S_ACK;
               end
            end
            S_ACK, S_ERROR: begin
               if (!r_as_s) begin
                  r_cs <= '0; r_oe <= 1'b0; r_we_u <= 1'b0; r_we_l <= 1'b0;
                  r_dtack <= 1'b0; r_dterror <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign CS        = r_cs;
   assign OE        = r_oe;
   assign WE_U      = r_we_u;
   assign WE_L      = r_we_l;
   assign DTACK     = r_dtack;
   assign DTERROR   = r_dterror;
   assign BUSY      = (r_state != S_IDLE);
   assign HIT_INDEX = r_hit_index;

endmodule
